// File: rtl/sync_fifo_pkg.sv
// Shared types and default widths for the synchronous FIFO burst reader.
`timescale 1ns/1ps
package sync_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int LEN_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order {last,data} buffer; entry 0 is always the head.
`timescale 1ns/1ps
module fifo_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last
);

    logic [DATA_WIDTH-1:0] e0_data_q, e0_data_d;
    logic [DATA_WIDTH-1:0] e1_data_q, e1_data_d;
    logic                  e0_last_q, e0_last_d;
    logic                  e1_last_q, e1_last_d;
    logic [1:0]            cnt_q, cnt_d;

    // Pop is applied first so a same-cycle push lands in the slot it frees.
    always_comb begin
        e0_data_d = e0_data_q;
        e0_last_d = e0_last_q;
        e1_data_d = e1_data_q;
        e1_last_d = e1_last_q;
        cnt_d     = cnt_q;
        if (pop && cnt_q != 2'd0) begin
            e0_data_d = e1_data_q;
            e0_last_d = e1_last_q;
            cnt_d     = cnt_q - 2'd1;
        end
        if (push && cnt_d != 2'd2) begin
            if (cnt_d == 2'd0) begin
                e0_data_d = push_data;
                e0_last_d = push_last;
            end else begin
                e1_data_d = push_data;
                e1_last_d = push_last;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_data_q <= '0;
            e0_last_q <= 1'b0;
            e1_data_q <= '0;
            e1_last_q <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            e0_data_q <= e0_data_d;
            e0_last_q <= e0_last_d;
            e1_data_q <= e1_data_d;
            e1_last_q <= e1_last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign head_data = e0_data_q;
    assign head_last = e0_last_q;

endmodule

// File: rtl/sync_fifo_burst_reader.sv
// Burst read master: pops burst_len words from a show-ahead FIFO and streams them out.
`timescale 1ns/1ps
module sync_fifo_burst_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_do,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output rd_state_t             dbg_state
);

    // Stream handshake: a word transfers on every cycle where m_valid & m_ready.
    // m_valid never drops and m_data/m_last hold while m_ready is low.

    rd_state_t            state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [1:0]           cnt;
    logic [DATA_WIDTH-1:0] head_data;
    logic                 head_last;
    logic                 beat;

    // Pop decision uses only registered state and fifo_empty, so it never
    // combinationally depends on the downstream consumer.
    assign fifo_rd = ~rst & (state_q == RUN) & (rem_q != '0) & ~fifo_empty & (cnt < 2'd2);
    assign beat    = m_valid & m_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d = RUN;
                        rem_d   = burst_len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (fifo_rd) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (beat && head_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_rd),
        .push_data (fifo_do),
        .push_last (rem_q == LEN_WIDTH'(1)),
        .pop       (beat),
        .cnt       (cnt),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign m_valid   = (cnt != 2'd0);
    assign m_data    = head_data;
    assign m_last    = head_last & m_valid;
    assign dbg_state = state_q;

endmodule
